// File: rtl/cape_gpio_iopads.sv
// cape_gpio_iopads: N-channel bidirectional cape-header GPIO pad block.
// Each channel has a tri-state pad buffer, an input synchroniser and
// rising/falling edge interrupt capture with a pending flag.
// Optional input debounce is compiled in when CAPE_GPIO_DEBOUNCE_EN is defined.

module cape_gpio_iopads #(
    parameter int N               = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         PCLK,
    input  logic         PRESETN,
    input  logic [N-1:0] GPIO_OUT,
    input  logic [N-1:0] GPIO_OE,
    output logic [N-1:0] GPIO_IN,
    input  logic [N-1:0] INT_RISE_EN,
    input  logic [N-1:0] INT_FALL_EN,
    input  logic [N-1:0] INT_CLR,
    output logic [N-1:0] INT_PEND,
    output logic         INT,
    inout  wire  [N-1:0] PAD
);

    localparam int               ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [N-1:0]     pad_y_s;
    logic [N-1:0]     sync_r [SYNC_STAGES];
    logic [N-1:0]     sync_last_s;
    logic [N-1:0]     next_in_s;
    logic [N-1:0]     gpio_in_r;
    logic [N-1:0]     rise_s;
    logic [N-1:0]     fall_s;
    logic [N-1:0]     set_s;
    logic [N-1:0]     pend_nxt_s;
    logic [N-1:0]     int_pend_r;
    logic [ARM_W-1:0] arm_cnt_r;
    logic             armed_s;

    // Illegal configurations are rejected at elaboration
    if (N < 1 || N > 32) begin : g_bad_n
        $error("cape_gpio_iopads: N must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("cape_gpio_iopads: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("cape_gpio_iopads: DEBOUNCE_CYCLES must be at least 1");
    end

    // Pad buffers: driver enabled by GPIO_OE, receiver always active.
    // Direction is purely combinational so reset never changes it.
    for (genvar g = 0; g < N; g++) begin : g_pad
        assign PAD[g] = GPIO_OE[g] ? GPIO_OUT[g] : 1'bz;
    end
    assign pad_y_s = PAD;

    // Metastability synchroniser chain; stage 0 samples the pad receivers
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= pad_y_s;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign sync_last_s = sync_r[SYNC_STAGES-1];

    // Arm counter: edges are ignored until the synchroniser has filled after reset
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            arm_cnt_r <= '0;
        end else if (arm_cnt_r != ARM_MAX) begin
            arm_cnt_r <= arm_cnt_r + ARM_W'(1);
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    assign armed_s = (arm_cnt_r == ARM_MAX);

`ifdef CAPE_GPIO_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_r     [N];
    logic [DB_W-1:0] db_cnt_nxt_s [N];

    // Stability filter: accept a new value only after it has differed for the full window
    always_comb begin
        next_in_s = gpio_in_r;
        for (int i = 0; i < N; i++) begin
            db_cnt_nxt_s[i] = '0;
            if (sync_last_s[i] == gpio_in_r[i]) begin
                db_cnt_nxt_s[i] = '0;
            end else if (db_cnt_r[i] == DB_LAST) begin
                next_in_s[i]    = sync_last_s[i];
                db_cnt_nxt_s[i] = '0;
            end else begin
                db_cnt_nxt_s[i] = db_cnt_r[i] + DB_W'(1);
            end
        end
    end

    // Per-channel stability counters
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < N; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                db_cnt_r[i] <= db_cnt_nxt_s[i];
            end
        end
    end
`else
    // Without debounce the synchroniser output is taken every cycle
    always_comb begin
        next_in_s = sync_last_s;
    end
`endif

    // Edge detection and pending update; a set in the same cycle as a clear wins
    always_comb begin
        rise_s = next_in_s & ~gpio_in_r;
        fall_s = ~next_in_s & gpio_in_r;
        if (armed_s) begin
            set_s = (rise_s & INT_RISE_EN) | (fall_s & INT_FALL_EN);
        end else begin
            set_s = '0;
        end
        pend_nxt_s = set_s | (int_pend_r & ~INT_CLR);
    end

    // Stable input value and pending flags update on the same edge
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            gpio_in_r  <= '0;
            int_pend_r <= '0;
        end else begin
            gpio_in_r  <= next_in_s;
            int_pend_r <= pend_nxt_s;
        end
    end

    assign GPIO_IN  = gpio_in_r;
    assign INT_PEND = int_pend_r;
    assign INT      = |int_pend_r;

endmodule
